trace_checker: RTL and testbench
================================

# trace_checker

Self-checking trace comparator that sits downstream of the CPU core's write-back debug port in trace-test builds. It consumes the per-instruction `debug_wb_*` stream, compares every retired instruction against a golden trace held in a synchronous trace ROM, and latches PASS/FAIL with first-mismatch diagnostics. It also owns the core's reset: the core is released only when the first golden entry is loaded, and it is held in reset again once a verdict is reached.

## Interface
- `TRACE_AW`, 16: trace ROM address width in entries.
- `TIMEOUT`, 4096: maximum idle cycles between retirements in RUN.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `trace_len  in  TRACE_AW+1`: number of valid golden entries. Must be stable from reset onward.
- `trace_addr  out  TRACE_AW`: trace ROM read address. Combinational from registered state.
- `trace_data  in  70`: ROM read data, equal to `mem[trace_addr]` of the previous cycle.
- `debug_wb_have_inst  in  1`: from the core.
- `debug_wb_pc  in  32`: from the core.
- `debug_wb_ena  in  1`: from the core.
- `debug_wb_reg  in  5`: from the core.
- `debug_wb_value  in  32`: from the core.
- `core_rst_n  out  1`: registered reset to the core; 1 only in RUN.
- `done`, `pass`, `fail  out  1 each`: verdict flags, sticky until reset.
- `fail_cause  out  2`: 0 none, 1 MISMATCH, 2 TIMEOUT.
- `inst_count  out  32`: number of matched retirements.
- `fail_index  out  TRACE_AW`: index of the expected entry at failure.
- `fail_pc  out  32`: actual PC at failure.
- `fail_exp_value  out  32`: expected value at failure.
- `fail_act_value  out  32`: actual value at failure.

## Operation
- Entry packing: `{pc[69:38], ena[37], reg[36:32], value[31:0]}`.
- States: INIT → LOAD → RUN → PASS | FAIL.
- INIT:
  - `trace_addr = 0`.
  - If `trace_len == 0`, go to PASS. Otherwise go to LOAD.
- LOAD:
  - `exp_q <= trace_data` (entry 0); `ptr <= 0`.
  - `trace_addr = 1`.
  - Go to RUN.
- RUN:
  - `trace_addr = ptr + 1 + accept`, truncated to TRACE_AW. This lookahead keeps `trace_data` equal to entry `ptr+1` on every cycle, so back-to-back retirements are sustained.
  - `accept = debug_wb_have_inst && match`.
  - `match` requires all of:
    - pc equal;
    - ena equal;
    - if ena is 1: reg equal;
    - if ena is 1 and reg is not 0: value equal.
    - Writes to x0 ignore value.
  - On accept:
    - `exp_q <= trace_data`;
    - `ptr++`;
    - `inst_count++`.
    - If `ptr + 1 == trace_len`, go to PASS.
  - On `have_inst && !match`: go to FAIL with cause MISMATCH. Latch `fail_index = ptr`, actual pc/value, and expected value.
  - Idle counter:
    - Clears on `have_inst`; increments otherwise.
    - When it reaches TIMEOUT-1 with no `have_inst`, go to FAIL with cause TIMEOUT. Latch `fail_index = ptr`; `fail_pc`/`fail_act_value` are 0.
- PASS / FAIL:
  - Terminal states.
  - `core_rst_n = 0`.
  - `debug_wb_*` inputs are ignored.
  - Only `rst_n` exits these states.
- `debug_wb_*` inputs are don't-care outside RUN.

## Timing
- Reset values:
  - state INIT; `core_rst_n` 0; `done`/`pass`/`fail` 0; `fail_cause` 0;
  - `inst_count` 0; all `fail_*` 0; `ptr` 0; idle counter 0.
- `core_rst_n` rises on the clock edge that enters RUN, which is the 2nd edge after `rst_n` deassertion. It falls on the edge that enters PASS or FAIL.
- The compare is combinational in the retirement cycle. The verdict and counters are visible on the following cycle, which is 1-cycle latency.
- Sustained rate is one compare per cycle with no stall.
- Last entry matched: `done` and `pass` assert the next cycle; `inst_count == trace_len`.
- Mismatch on the last entry: FAIL. Mismatch has priority over completion.
- `have_inst` in the same cycle the idle count hits its limit: the retirement is compared and the timeout is suppressed.
- `trace_len = 1`: INIT → LOAD → RUN; PASS follows the first match.
- `rst_n` asserted mid-run: all registers return to reset values immediately (asynchronous), and `core_rst_n` drops at once.

## Structure
- Package `trace_pkg`:
  - entry width 70 and field bit positions;
  - state enum `{INIT, LOAD, RUN, PASS, FAIL}`;
  - `fail_cause` codes.
- One sub-module, `trace_entry_cmp`: purely combinational; inputs are the expected entry and the actual wb fields, output is `match`.
- FSM, pointer, counters and latches live in `trace_checker`.

## Test plan
- `trace_len = 3`; core retires entries 0,1,2 exactly on back-to-back cycles → `pass = 1` one cycle after the third, `inst_count = 3`, `trace_addr` sequence 0,1,2,3,4.
- Entry 1 expects value 0x0000_00AA; core writes 0x0000_00AB → `fail = 1`, `fail_cause = 1`, `fail_index = 1`, `fail_exp_value = 0xAA`, `fail_act_value = 0xAB`, `core_rst_n = 0`.
- Expected write to x0 with value 5; actual write to x0 with value 9 → accepted, `inst_count` increments.
- `TIMEOUT = 16`; entry 0 matched, then no `have_inst` → FAIL with cause 2 after 16 idle cycles, `fail_index = 1`.
- `trace_len = 0` → `pass = 1` one cycle after reset release, `core_rst_n` never rises.
- Retirements spaced 1 to 5 cycles apart with `rst_n` asserted mid-run, then a fresh run → outputs return to reset values immediately, and the second run passes independently.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - golden trace entry layout, checker FSM states and failure codes
package trace_pkg;

    localparam int ENTRY_W = 70;
    localparam int PC_MSB  = 69;
    localparam int PC_LSB  = 38;
    localparam int ENA_BIT = 37;
    localparam int REG_MSB = 36;
    localparam int REG_LSB = 32;
    localparam int VAL_MSB = 31;
    localparam int VAL_LSB = 0;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        PASS = 3'd3,
        FAIL = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [31:0] pc,
        input logic        ena,
        input logic [4:0]  rd,
        input logic [31:0] value
    );
        return {pc, ena, rd, value};
    endfunction

endpackage

// File: rtl/trace_entry_cmp.sv
// rtl/trace_entry_cmp.sv - combinational compare of one retired instruction against a golden entry
module trace_entry_cmp
    import trace_pkg::*;
(
    input  logic [ENTRY_W-1:0] exp_entry,
    input  logic [31:0]        act_pc,
    input  logic               act_ena,
    input  logic [4:0]         act_reg,
    input  logic [31:0]        act_value,
    output logic               match
);

    logic [31:0] exp_pc;
    logic        exp_ena;
    logic [4:0]  exp_reg;
    logic [31:0] exp_value;
    logic        pc_eq;
    logic        ena_eq;
    logic        reg_eq;
    logic        value_eq;

    assign exp_pc    = exp_entry[PC_MSB:PC_LSB];
    assign exp_ena   = exp_entry[ENA_BIT];
    assign exp_reg   = exp_entry[REG_MSB:REG_LSB];
    assign exp_value = exp_entry[VAL_MSB:VAL_LSB];

    assign pc_eq    = (exp_pc == act_pc);
    assign ena_eq   = (exp_ena == act_ena);
    assign reg_eq   = (exp_reg == act_reg);
    assign value_eq = (exp_value == act_value);

    // x0 writes are architecturally discarded, so their value is not compared
    assign match = pc_eq && ena_eq &&
                   (!exp_ena || (reg_eq && ((exp_reg == 5'd0) || value_eq)));

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares the core write-back stream against a golden trace ROM and latches a verdict
module trace_checker
    import trace_pkg::*;
#(
    parameter int TRACE_AW = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TRACE_AW:0]   trace_len,
    output logic [TRACE_AW-1:0] trace_addr,
    input  logic [ENTRY_W-1:0]  trace_data,
    input  logic                debug_wb_have_inst,
    input  logic [31:0]         debug_wb_pc,
    input  logic                debug_wb_ena,
    input  logic [4:0]          debug_wb_reg,
    input  logic [31:0]         debug_wb_value,
    output logic                core_rst_n,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          fail_cause,
    output logic [31:0]         inst_count,
    output logic [TRACE_AW-1:0] fail_index,
    output logic [31:0]         fail_pc,
    output logic [31:0]         fail_exp_value,
    output logic [31:0]         fail_act_value
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_t               state;
    logic [ENTRY_W-1:0]   exp_q;
    logic [TRACE_AW-1:0]  ptr;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 match;
    logic                 accept;
    logic                 last_entry;

    trace_entry_cmp u_cmp (
        .exp_entry (exp_q),
        .act_pc    (debug_wb_pc),
        .act_ena   (debug_wb_ena),
        .act_reg   (debug_wb_reg),
        .act_value (debug_wb_value),
        .match     (match)
    );

    assign accept     = (state == RUN) && debug_wb_have_inst && match;
    assign last_entry = (({1'b0, ptr} + (TRACE_AW + 1)'(1)) == trace_len);

    // Lookahead address: trace_data always holds entry ptr+1, even right after an accept
    always_comb begin
        trace_addr = '0;
        case (state)
            INIT:    trace_addr = '0;
            LOAD:    trace_addr = TRACE_AW'(1);
            RUN:     trace_addr = ptr + TRACE_AW'(1) + TRACE_AW'(accept);
            default: trace_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            exp_q          <= '0;
            ptr            <= '0;
            idle_cnt       <= '0;
            core_rst_n     <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            fail_cause     <= CAUSE_NONE;
            inst_count     <= '0;
            fail_index     <= '0;
            fail_pc        <= '0;
            fail_exp_value <= '0;
            fail_act_value <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (trace_len == '0) begin
                        state <= PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    exp_q      <= trace_data;
                    ptr        <= '0;
                    idle_cnt   <= '0;
                    core_rst_n <= 1'b1;
                    state      <= RUN;
                end

                RUN: begin
                    if (debug_wb_have_inst) begin
                        idle_cnt <= '0;
                        if (match) begin
                            exp_q      <= trace_data;
                            ptr        <= ptr + TRACE_AW'(1);
                            inst_count <= inst_count + 32'd1;
                            if (last_entry) begin
                                state      <= PASS;
                                done       <= 1'b1;
                                pass       <= 1'b1;
                                core_rst_n <= 1'b0;
                            end
                        end else begin
                            state          <= FAIL;
                            done           <= 1'b1;
                            fail           <= 1'b1;
                            fail_cause     <= CAUSE_MISMATCH;
                            fail_index     <= ptr;
                            fail_pc        <= debug_wb_pc;
                            fail_exp_value <= exp_q[VAL_MSB:VAL_LSB];
                            fail_act_value <= debug_wb_value;
                            core_rst_n     <= 1'b0;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        // No actual instruction exists, so actual pc/value stay zero
                        state          <= FAIL;
                        done           <= 1'b1;
                        fail           <= 1'b1;
                        fail_cause     <= CAUSE_TIMEOUT;
                        fail_index     <= ptr;
                        fail_pc        <= '0;
                        fail_exp_value <= exp_q[VAL_MSB:VAL_LSB];
                        fail_act_value <= '0;
                        core_rst_n     <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed scoreboard bench for trace_checker
module tb_trace_checker;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW:0]   trace_len = '0;
    logic [AW-1:0] trace_addr;
    logic [69:0]   trace_data = '0;
    logic          debug_wb_have_inst = 1'b0;
    logic [31:0]   debug_wb_pc = '0;
    logic          debug_wb_ena = 1'b0;
    logic [4:0]    debug_wb_reg = '0;
    logic [31:0]   debug_wb_value = '0;
    logic          core_rst_n;
    logic          done;
    logic          pass;
    logic          fail;
    logic [1:0]    fail_cause;
    logic [31:0]   inst_count;
    logic [AW-1:0] fail_index;
    logic [31:0]   fail_pc;
    logic [31:0]   fail_exp_value;
    logic [31:0]   fail_act_value;

    logic [69:0]   rom [0:15];
    logic [31:0]   sb_q [$];
    logic [31:0]   model_cnt = '0;
    int            n_assert = 0;
    int            n_fail = 0;

    trace_checker #(.TRACE_AW(AW), .TIMEOUT(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .trace_len          (trace_len),
        .trace_addr         (trace_addr),
        .trace_data         (trace_data),
        .debug_wb_have_inst (debug_wb_have_inst),
        .debug_wb_pc        (debug_wb_pc),
        .debug_wb_ena       (debug_wb_ena),
        .debug_wb_reg       (debug_wb_reg),
        .debug_wb_value     (debug_wb_value),
        .core_rst_n         (core_rst_n),
        .done               (done),
        .pass               (pass),
        .fail               (fail),
        .fail_cause         (fail_cause),
        .inst_count         (inst_count),
        .fail_index         (fail_index),
        .fail_pc            (fail_pc),
        .fail_exp_value     (fail_exp_value),
        .fail_act_value     (fail_act_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) trace_data <= rom[trace_addr[3:0]];

    initial begin
        #100000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [69:0] ent(input logic [31:0] p, input logic e,
                                        input logic [4:0] r, input logic [31:0] v);
        return {p, e, r, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        logic [31:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("inst_count", inst_count, e);
        end
    endtask

    task automatic retire(input logic [69:0] en, input bit acc);
        @(negedge clk);
        sb_check();
        {debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value} = en;
        debug_wb_have_inst = 1'b1;
        if (acc) model_cnt++;
        sb_q.push_back(model_cnt);
    endtask

    task automatic idle();
        @(negedge clk);
        sb_check();
        debug_wb_have_inst = 1'b0;
    endtask

    task automatic start(input int len);
        rst_n = 1'b0;
        debug_wb_have_inst = 1'b0;
        trace_len = (AW + 1)'(len);
        sb_q.delete();
        model_cnt = '0;
        repeat (2) @(negedge clk);
        check("rst_done", 32'(done), 0);
        check("rst_core_rst_n", 32'(core_rst_n), 0);
        check("rst_inst_count", inst_count, 0);
        rst_n = 1'b1;
        #1 check("addr_init", 32'(trace_addr), 0);
    endtask

    initial begin
        int idle_n;
        foreach (rom[i]) rom[i] = '0;

        // back-to-back pass, trace_len = 3
        rom[0] = ent(32'h1000, 1'b1, 5'd1, 32'h11);
        rom[1] = ent(32'h1004, 1'b1, 5'd2, 32'h22);
        rom[2] = ent(32'h1008, 1'b0, 5'd0, 32'h0);
        start(3);
        check("rst_fail_cause", 32'(fail_cause), 0);
        check("rst_fail_index", 32'(fail_index), 0);
        check("rst_fail_pc", fail_pc, 0);
        @(negedge clk);
        #1 check("addr_load", 32'(trace_addr), 1);
        check("core_rst_load", 32'(core_rst_n), 0);
        retire(rom[0], 1'b1);
        #1 check("addr_run0", 32'(trace_addr), 2);
        check("core_rst_run", 32'(core_rst_n), 1);
        retire(rom[1], 1'b1);
        #1 check("addr_run1", 32'(trace_addr), 3);
        retire(rom[2], 1'b1);
        #1 check("addr_run2", 32'(trace_addr), 4);
        idle();
        check("t1_pass", 32'(pass), 1);
        check("t1_done", 32'(done), 1);
        check("t1_fail", 32'(fail), 0);
        check("t1_core_rst", 32'(core_rst_n), 0);
        check("t1_count", inst_count, 3);

        // value mismatch on entry 1
        rom[0] = ent(32'h2000, 1'b1, 5'd1, 32'h1);
        rom[1] = ent(32'h2004, 1'b1, 5'd3, 32'hAA);
        rom[2] = ent(32'h2008, 1'b1, 5'd4, 32'h4);
        start(3);
        @(negedge clk);
        retire(rom[0], 1'b1);
        retire(ent(32'h2004, 1'b1, 5'd3, 32'hAB), 1'b0);
        idle();
        check("t2_fail", 32'(fail), 1);
        check("t2_pass", 32'(pass), 0);
        check("t2_cause", 32'(fail_cause), 1);
        check("t2_index", 32'(fail_index), 1);
        check("t2_pc", fail_pc, 32'h2004);
        check("t2_exp", fail_exp_value, 32'hAA);
        check("t2_act", fail_act_value, 32'hAB);
        check("t2_core_rst", 32'(core_rst_n), 0);
        retire(rom[2], 1'b0);
        idle();
        check("t2_sticky", 32'(fail), 1);

        // x0 write value ignored, ena=0 ignores reg/value
        rom[0] = ent(32'h3000, 1'b1, 5'd0, 32'h5);
        rom[1] = ent(32'h3004, 1'b0, 5'd7, 32'h77);
        start(2);
        @(negedge clk);
        retire(ent(32'h3000, 1'b1, 5'd0, 32'h9), 1'b1);
        retire(ent(32'h3004, 1'b0, 5'd9, 32'h1234), 1'b1);
        idle();
        check("t3_pass", 32'(pass), 1);
        check("t3_count", inst_count, 2);

        // timeout after 16 idle cycles
        rom[0] = ent(32'h4000, 1'b1, 5'd1, 32'h1);
        rom[1] = ent(32'h4004, 1'b1, 5'd2, 32'h2);
        rom[2] = ent(32'h4008, 1'b1, 5'd3, 32'h3);
        start(3);
        @(negedge clk);
        retire(rom[0], 1'b1);
        idle_n = -1;
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (fail === 1'b1) begin
                idle_n = i - 1;
                break;
            end
        end
        check("t4_idle_cycles", 32'(idle_n), 16);
        check("t4_cause", 32'(fail_cause), 2);
        check("t4_index", 32'(fail_index), 1);
        check("t4_pc", fail_pc, 0);
        check("t4_act", fail_act_value, 0);
        check("t4_core_rst", 32'(core_rst_n), 0);

        // retirement on the final idle cycle suppresses timeout
        start(2);
        @(negedge clk);
        retire(rom[0], 1'b1);
        repeat (15) idle();
        retire(rom[1], 1'b1);
        idle();
        check("t4b_pass", 32'(pass), 1);
        check("t4b_fail", 32'(fail), 0);

        // empty trace
        start(0);
        @(negedge clk);
        check("t5_pass", 32'(pass), 1);
        check("t5_done", 32'(done), 1);
        check("t5_core_rst", 32'(core_rst_n), 0);
        repeat (3) @(negedge clk);
        check("t5_core_rst_hold", 32'(core_rst_n), 0);
        check("t5_count", inst_count, 0);

        // spaced retirements, async reset mid-run, then fresh run
        for (int i = 0; i < 4; i++)
            rom[i] = ent(32'h6000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(3 * i + 1));
        start(4);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            repeat (i + 1) idle();
            retire(rom[i], 1'b1);
        end
        idle();
        idle();
        check("t6_mid_core_rst", 32'(core_rst_n), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("t6_async_core_rst", 32'(core_rst_n), 0);
        check("t6_async_count", inst_count, 0);
        check("t6_async_done", 32'(done), 0);
        start(4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            repeat (i + 1) idle();
            retire(rom[i], 1'b1);
        end
        idle();
        check("t6_pass", 32'(pass), 1);
        check("t6_count", inst_count, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
